// File: rtl/sa2_operand_feeder_if.sv
// Byte-stream bundle between the host DMA and the systolic-array feeder:
// activation/weight input stream plus the result output stream.
interface sa2_operand_feeder_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sa2_operand_feeder.sv
// Stream front end for the 2x2 convolution systolic array: deserialises 16
// activations and 9 weights, runs the array, then serialises the 4 results.
module sa2_operand_feeder #(
    parameter int DATA_W     = 8,
    parameter int ACTIVE_MAX = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    sa2_operand_feeder_if.slave   stream,
    output logic [16*DATA_W-1:0]  a_flat,
    output logic [9*DATA_W-1:0]   b_flat,
    output logic                  active_sa2,
    input  logic                  done_sa2,
    input  logic [4*DATA_W-1:0]   c_flat,
    output logic                  frame_done,
    output logic                  timeout
);
    localparam int CNT_W = (ACTIVE_MAX > 2) ? $clog2(ACTIVE_MAX) : 1;

    typedef enum logic [1:0] {LOAD_A, LOAD_B, RUN, OUT} state_t;

    state_t            state_reg, state_next;
    logic [3:0]        idx_reg, idx_next;
    logic [CNT_W-1:0]  run_cnt_reg, run_cnt_next;
    logic [1:0]        ridx_reg, ridx_next;
    logic              in_ready_reg, active_reg, out_valid_reg;
    logic              frame_done_reg, frame_done_next;
    logic              timeout_reg, timeout_next;
    logic              accept, out_fire;
    logic              a_we, b_we, res_load, res_clear;

    logic [DATA_W-1:0] a_reg   [16];
    logic [DATA_W-1:0] b_reg   [9];
    logic [DATA_W-1:0] res_reg [4];

    assign accept   = stream.in_valid && in_ready_reg;
    assign out_fire = out_valid_reg && stream.out_ready;

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        run_cnt_next    = run_cnt_reg;
        ridx_next       = ridx_reg;
        frame_done_next = 1'b0;
        timeout_next    = 1'b0;
        a_we            = 1'b0;
        b_we            = 1'b0;
        res_load        = 1'b0;
        res_clear       = 1'b0;
        case (state_reg)
            LOAD_A: begin
                if (accept) begin
                    a_we = 1'b1;
                    if (idx_reg == 4'd15) begin
                        idx_next   = 4'd0;
                        state_next = LOAD_B;
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end
            end
            LOAD_B: begin
                if (accept) begin
                    b_we = 1'b1;
                    if (idx_reg == 4'd8) begin
                        idx_next   = 4'd0;
                        state_next = RUN;
                    end else begin
                        idx_next = idx_reg + 4'd1;
                    end
                end
            end
            RUN: begin
                run_cnt_next = run_cnt_reg + 1'b1;
                // done has priority over an expiring run counter
                if (done_sa2) begin
                    res_load     = 1'b1;
                    run_cnt_next = '0;
                    state_next   = OUT;
                end else if (run_cnt_reg == CNT_W'(ACTIVE_MAX - 1)) begin
                    res_clear    = 1'b1;
                    timeout_next = 1'b1;
                    run_cnt_next = '0;
                    state_next   = OUT;
                end
            end
            OUT: begin
                if (out_fire) begin
                    if (ridx_reg == 2'd3) begin
                        ridx_next       = 2'd0;
                        frame_done_next = 1'b1;
                        state_next      = LOAD_A;
                    end else begin
                        ridx_next = ridx_reg + 2'd1;
                    end
                end
            end
            default: state_next = LOAD_A;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= LOAD_A;
            idx_reg        <= 4'd0;
            run_cnt_reg    <= '0;
            ridx_reg       <= 2'd0;
            in_ready_reg   <= 1'b0;
            active_reg     <= 1'b0;
            out_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            run_cnt_reg    <= run_cnt_next;
            ridx_reg       <= ridx_next;
            in_ready_reg   <= (state_next == LOAD_A) || (state_next == LOAD_B);
            active_reg     <= (state_next == RUN);
            out_valid_reg  <= (state_next == OUT);
            frame_done_reg <= frame_done_next;
            timeout_reg    <= timeout_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_a
            always_ff @(posedge clk) begin
                if (rst)
                    a_reg[gi] <= '0;
                else if (a_we && idx_reg == 4'(gi))
                    a_reg[gi] <= stream.in_data;
            end
            assign a_flat[gi*DATA_W +: DATA_W] = a_reg[gi];
        end

        for (gi = 0; gi < 9; gi++) begin : g_b
            always_ff @(posedge clk) begin
                if (rst)
                    b_reg[gi] <= '0;
                else if (b_we && idx_reg == 4'(gi))
                    b_reg[gi] <= stream.in_data;
            end
            assign b_flat[gi*DATA_W +: DATA_W] = b_reg[gi];
        end

        for (gi = 0; gi < 4; gi++) begin : g_res
            always_ff @(posedge clk) begin
                if (rst || res_clear)
                    res_reg[gi] <= '0;
                else if (res_load)
                    res_reg[gi] <= c_flat[gi*DATA_W +: DATA_W];
            end
        end
    endgenerate

    assign stream.in_ready  = in_ready_reg;
    assign stream.out_valid = out_valid_reg;
    assign stream.out_data  = res_reg[ridx_reg];
    assign active_sa2       = active_reg;
    assign frame_done       = frame_done_reg;
    assign timeout          = timeout_reg;
endmodule
